ps2_wasd_decoder: RTL and testbench

Receives a PS/2 keyboard stream (scan-code set 2) and produces the held-key levels `w`, `a`, `s`, `d` consumed by the game top level. The block is the producing end of those four inputs. It sits between the board's PS/2 pins and the top level, in the 50 MHz system clock domain. It synchronises and filters the PS/2 lines, deframes 11-bit frames with parity, stop and timeout checking, and tracks make/break/extended prefixes.

---
 rtl/ps2_wasd_decoder.sv | 155 +++++++++++++++
 tb/tb_ps2_wasd_decoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_wasd_decoder.sv
// PS/2 (scan-code set 2) receiver. Produces held-key levels for W/A/S/D, the last byte
// received correctly, and one-cycle valid and error pulses.
module ps2_wasd_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       w,
    output logic       a,
    output logic       s,
    output logic       d,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    localparam logic [7:0]  FILT_MAX = 8'(FILTER_LEN - 1);
    localparam logic [15:0] TO_MAX   = 16'(TIMEOUT_CYCLES - 1);

    logic        clk_s1, clk_s2, dat_s1, dat_s2;
    logic        filt_clk, filt_prev;
    logic [7:0]  filt_cnt;
    logic        strobe;
    state_t      state, next_state;
    logic [10:0] frame;
    logic [3:0]  bit_cnt;
    logic [15:0] idle_cnt;
    logic        timeout, frame_ok;
    logic        brk, ext;
    logic [7:0]  rx_byte;

    // The filtered clock changes only after FILTER_LEN consecutive samples that
    // disagree with it, so short glitches never reach the edge detector.
    // NOTE: every clocked block uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_s1    <= ps2_clk;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_data;
            dat_s2    <= dat_s1;
            filt_prev <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end
    end

    assign strobe   = filt_prev & ~filt_clk;
    assign timeout  = (state == RECV) && (idle_cnt == TO_MAX);
    assign rx_byte  = frame[8:1];
    assign frame_ok = (^frame[9:1]) && frame[10];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: defaults first so no path through this block leaves an output unassigned (no latches).
    always_comb begin
        next_state  = state;
        scan_valid  = 1'b0;
        frame_error = 1'b0;
        case (state)
            IDLE:  if (strobe && !dat_s2) next_state = RECV;
            RECV: begin
                if (timeout) begin
                    frame_error = 1'b1;
                    next_state  = IDLE;
                end else if (strobe && bit_cnt == 4'd10) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                scan_valid  = frame_ok;
                frame_error = ~frame_ok;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Bits enter at the top so after 11 strobes the start bit sits in frame[0].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame    <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            if (state == RECV && !strobe) idle_cnt <= idle_cnt + 16'd1;
            else                          idle_cnt <= '0;
            if (state == IDLE && strobe && !dat_s2) begin
                frame   <= {dat_s2, frame[10:1]};
                bit_cnt <= 4'd1;
            end else if (state == RECV && strobe && !timeout) begin
                frame   <= {dat_s2, frame[10:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end else if (state != RECV) begin
                bit_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_code <= '0;
            brk       <= 1'b0;
            ext       <= 1'b0;
            w         <= 1'b0;
            a         <= 1'b0;
            s         <= 1'b0;
            d         <= 1'b0;
        end else if (scan_valid) begin
            scan_code <= rx_byte;
            if (rx_byte == 8'hF0) begin
                brk <= 1'b1;
            end else if (rx_byte == 8'hE0) begin
                ext <= 1'b1;
            end else begin
                if (!ext) begin
                    case (rx_byte)
                        8'h1D:   w <= ~brk;
                        8'h1C:   a <= ~brk;
                        8'h1B:   s <= ~brk;
                        8'h23:   d <= ~brk;
                        default: ;
                    endcase
                end
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end else if (frame_error) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_wasd_decoder.sv
// Directed bench for ps2_wasd_decoder: drives PS/2 frames bit by bit and checks key
// levels, received codes and error pulses against hand-computed values.
module tb_ps2_wasd_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       w, a, s, d;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_error;

    int checks = 0;
    int errors = 0;

    int       cycle = 0;
    int       valid_cnt = 0;
    int       err_cnt = 0;
    int       overlap = 0;
    int       run_v = 0, run_e = 0, max_run_v = 0, max_run_e = 0;
    logic     prev_valid = 1'b0;
    logic [7:0] code_q[$];

    ps2_wasd_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .w           (w),
        .a           (a),
        .s           (s),
        .d           (d),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .frame_error (frame_error)
    );

    always #10 clk = ~clk;

    // Passive observer: counts pulses and records scan_code the cycle after each valid.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (prev_valid) code_q.push_back(scan_code);
        prev_valid = scan_valid;
        if (scan_valid) valid_cnt = valid_cnt + 1;
        if (frame_error) err_cnt = err_cnt + 1;
        if (scan_valid && frame_error) overlap = overlap + 1;
        run_v = scan_valid  ? run_v + 1 : 0;
        run_e = frame_error ? run_e + 1 : 0;
        if (run_v > max_run_v) max_run_v = run_v;
        if (run_e > max_run_e) max_run_e = run_e;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cycles(10);
        ps2_clk = 1'b0;
        wait_cycles(20);
        ps2_clk = 1'b1;
        wait_cycles(10);
    endtask

    // Odd parity: data ones plus parity bit is odd. bad_parity flips it.
    task automatic send_frame(input logic [7:0] code, input logic bad_parity = 1'b0);
        logic [10:0] bits;
        bits = {1'b1, (~^code) ^ bad_parity, code, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
        wait_cycles(4);
    endtask

    task automatic send_partial(input logic [7:0] code, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, ~^code, code, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
    endtask

    task automatic expect_keys(input string name, input logic [3:0] exp);
        checks++;
        if ({w, a, s, d} !== exp) begin
            errors++;
            $display("FAIL %s: wasd=%b expected %b", name, {w, a, s, d}, exp);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({w, a, s, d, scan_code, scan_valid, frame_error} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: wasd=%b code=%h v=%b e=%b expected all zero",
                     {w, a, s, d}, scan_code, scan_valid, frame_error);
        end
    endtask

    task automatic test_make_break;
        int v0, n0;
        v0 = valid_cnt;
        n0 = code_q.size();
        send_frame(8'h1D);
        expect_keys("make_w", 4'b1000);
        send_frame(8'hF0);
        expect_keys("prefix_f0_keeps_w", 4'b1000);
        send_frame(8'h1D);
        expect_keys("break_w", 4'b0000);
        checks++;
        if (valid_cnt - v0 !== 3) begin
            errors++;
            $display("FAIL make_break_valid_count: got %0d expected 3", valid_cnt - v0);
        end
        checks++;
        if (code_q.size() < n0 + 3) begin
            errors++;
            $display("FAIL make_break_codes: only %0d codes recorded expected 3", code_q.size() - n0);
        end else if ({code_q[n0], code_q[n0+1], code_q[n0+2]} !== 24'h1DF01D) begin
            errors++;
            $display("FAIL make_break_codes: got %h %h %h expected 1d f0 1d",
                     code_q[n0], code_q[n0+1], code_q[n0+2]);
        end
    endtask

    task automatic test_multi_key;
        send_frame(8'h1C);
        send_frame(8'h23);
        expect_keys("make_a_d", 4'b0101);
        send_frame(8'hF0);
        send_frame(8'h1C);
        expect_keys("break_a_keep_d", 4'b0001);
        send_frame(8'hF0);
        send_frame(8'h1B);
        expect_keys("break_unheld_s", 4'b0001);
        send_frame(8'h23);
        expect_keys("typematic_d", 4'b0001);
        send_frame(8'hF0);
        send_frame(8'h23);
        expect_keys("break_d", 4'b0000);
    endtask

    task automatic test_extended;
        int v0;
        v0 = valid_cnt;
        send_frame(8'hE0);
        send_frame(8'h1D);
        expect_keys("ext_make_ignored", 4'b0000);
        checks++;
        if (valid_cnt - v0 !== 2) begin
            errors++;
            $display("FAIL ext_valid_count: got %0d expected 2", valid_cnt - v0);
        end
        send_frame(8'h1D);
        expect_keys("make_w_after_ext", 4'b1000);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h1D);
        expect_keys("ext_break_ignored", 4'b1000);
        send_frame(8'hF0);
        send_frame(8'h1D);
        expect_keys("break_w_after_ext", 4'b0000);
    endtask

    task automatic test_parity_error;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h1D, 1'b1);
        checks++;
        if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
            errors++;
            $display("FAIL parity_error_pulse: errors=%0d valids=%0d expected 1 and 0",
                     err_cnt - e0, valid_cnt - v0);
        end
        expect_keys("parity_error_no_key", 4'b0000);
        send_frame(8'h1D);
        expect_keys("make_w_after_error", 4'b1000);
        send_frame(8'hF0);
        send_frame(8'h1D);
        expect_keys("break_w_before_flag_test", 4'b0000);
        send_frame(8'hF0);
        send_frame(8'h1D, 1'b1);
        send_frame(8'h1D);
        expect_keys("error_clears_brk", 4'b1000);
    endtask

    task automatic test_timeout;
        int e0, v0;
        e0 = err_cnt;
        send_partial(8'h1B, 6);
        wait_cycles(49000);
        checks++;
        if (err_cnt !== e0) begin
            errors++;
            $display("FAIL timeout_early: errors=%0d expected 0 before timeout", err_cnt - e0);
        end
        wait_cycles(2000);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL timeout_pulse: errors=%0d expected 1", err_cnt - e0);
        end
        v0 = valid_cnt;
        send_frame(8'h1B);
        expect_keys("make_s_after_timeout", 4'b1010);
        checks++;
        if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL after_timeout_frame: valids=%0d errors=%0d expected 1 and 1",
                     valid_cnt - v0, err_cnt - e0);
        end
    endtask

    task automatic test_glitch;
        int v0, e0, n0;
        v0 = valid_cnt;
        e0 = err_cnt;
        ps2_data = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ps2_clk = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(20);
        end
        ps2_data = 1'b1;
        wait_cycles(20);
        checks++;
        if (valid_cnt !== v0 || err_cnt !== e0) begin
            errors++;
            $display("FAIL glitch_no_activity: valids=%0d errors=%0d expected 0 and 0",
                     valid_cnt - v0, err_cnt - e0);
        end
        n0 = code_q.size();
        send_frame(8'h1C);
        checks++;
        if (code_q.size() != n0 + 1 || err_cnt !== e0) begin
            errors++;
            $display("FAIL glitch_then_frame: codes=%0d errors=%0d expected 1 and 0",
                     code_q.size() - n0, err_cnt - e0);
        end else if (code_q[n0] !== 8'h1C) begin
            errors++;
            $display("FAIL glitch_then_frame_code: got %h expected 1c", code_q[n0]);
        end
        expect_keys("glitch_then_make_a", 4'b1110);
    endtask

    task automatic test_reset_mid_frame;
        int e0, v0;
        send_partial(8'h23, 5);
        e0 = err_cnt;
        reset = 1'b0;
        #2;
        checks++;
        if ({w, a, s, d, scan_code, scan_valid, frame_error} !== 14'h0) begin
            errors++;
            $display("FAIL reset_mid_frame_outputs: wasd=%b code=%h v=%b e=%b expected all zero",
                     {w, a, s, d}, scan_code, scan_valid, frame_error);
        end
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(4);
        v0 = valid_cnt;
        send_frame(8'h1D);
        expect_keys("make_w_after_reset", 4'b1000);
        checks++;
        if (err_cnt !== e0 || valid_cnt - v0 !== 1) begin
            errors++;
            $display("FAIL reset_mid_frame_errors: errors=%0d valids=%0d expected 0 and 1",
                     err_cnt - e0, valid_cnt - v0);
        end
    endtask

    task automatic test_pulse_rules;
        checks++;
        if (overlap !== 0 || max_run_v !== 1 || max_run_e !== 1) begin
            errors++;
            $display("FAIL pulse_rules: overlap=%0d max_valid=%0d max_error=%0d expected 0 1 1",
                     overlap, max_run_v, max_run_e);
        end
    endtask

    initial begin
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(5);
        test_reset;
        reset = 1'b1;
        wait_cycles(5);
        test_make_break;
        test_multi_key;
        test_extended;
        test_parity_error;
        test_timeout;
        test_glitch;
        test_reset_mid_frame;
        test_pulse_rules;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
